// File: rtl/tx_frame_scheduler.sv
// Transmit frame scheduler: collects a packet, latches the sorted frame and shifts it out LSB first.
// Build option TX_SCHED_PARITY_EN appends an even-parity bit after the last frame bit.
module tx_frame_scheduler #(
    parameter int PACKET_WIDTH    = 4,
    parameter int INDEX_WIDTH     = 2,
    parameter int PREAMBLE_LENGTH = 8,
    parameter int BIT_PERIOD      = 4,
    parameter int GAP_CYCLES      = 8,
    localparam int FRAME_BITS     = PACKET_WIDTH*(8+INDEX_WIDTH)+PREAMBLE_LENGTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic [PACKET_WIDTH*8-1:0] sys_packet,
    input  logic [FRAME_BITS-1:0]     sorted_packet_in,
    output logic                      bit_out,
    output logic                      bit_valid,
    output logic                      bit_strobe,
    output logic                      busy,
    output logic                      frame_done
);

    // state | meaning
    // FILL  | accept PACKET_WIDTH bytes into sys_packet
    // LOAD  | one cycle for the sorter to settle, then latch its frame
    // SEND  | shift frame_sr out, BIT_PERIOD clocks per bit
    // GAP   | frame_done cycle plus GAP_CYCLES idle clocks
    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

`ifdef TX_SCHED_PARITY_EN
    localparam int SR_BITS = FRAME_BITS + 1;
`else
    localparam int SR_BITS = FRAME_BITS;
`endif

    localparam int BCW = $clog2(PACKET_WIDTH + 1);
    localparam int BTW = $clog2(SR_BITS + 1);
    localparam int PCW = $clog2(BIT_PERIOD + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 2);

    logic [1:0]         state;
    logic [BCW-1:0]     byte_cnt;
    logic [BTW-1:0]     bit_cnt;
    logic [PCW-1:0]     per_cnt;
    logic [GCW-1:0]     gap_cnt;
    logic [SR_BITS-1:0] frame_sr;
    logic [SR_BITS-1:0] load_val;
    logic               last_clk;
    logic               last_bit;

`ifdef TX_SCHED_PARITY_EN
    // parity rides in the top shift-register bit so it leaves right after the frame
    assign load_val = {^sorted_packet_in, sorted_packet_in};
`else
    assign load_val = sorted_packet_in;
`endif

    assign last_clk = (per_cnt == PCW'(BIT_PERIOD - 1));
    assign last_bit = (bit_cnt == BTW'(SR_BITS - 1));

    assign byte_ready = (state == ST_FILL) && !rst;
    assign busy       = (state != ST_FILL);
    assign bit_valid  = (state == ST_SEND);
    assign bit_out    = bit_valid && frame_sr[0];
    assign bit_strobe = bit_valid && (per_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FILL;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            gap_cnt    <= '0;
            frame_sr   <= '0;
            sys_packet <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (byte_valid) begin
                        for (int k = 0; k < PACKET_WIDTH; k++) begin
                            if (byte_cnt == BCW'(k)) begin
                                sys_packet[8*k +: 8] <= byte_in;
                            end
                        end
                        if (byte_cnt == BCW'(PACKET_WIDTH - 1)) begin
                            byte_cnt <= '0;
                            state    <= ST_LOAD;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    frame_sr <= load_val;
                    bit_cnt  <= '0;
                    per_cnt  <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (last_clk) begin
                        per_cnt  <= '0;
                        frame_sr <= frame_sr >> 1;
                        if (last_bit) begin
                            bit_cnt    <= '0;
                            gap_cnt    <= '0;
                            frame_done <= 1'b1;
                            state      <= (GAP_CYCLES == 0) ? ST_FILL : ST_GAP;
                        end else begin
                            bit_cnt <= bit_cnt + BTW'(1);
                        end
                    end else begin
                        per_cnt <= per_cnt + PCW'(1);
                    end
                end
                default: begin
                    // first GAP clock carries frame_done, the remaining GAP_CYCLES are idle
                    if (gap_cnt == GCW'(GAP_CYCLES)) begin
                        gap_cnt <= '0;
                        state   <= ST_FILL;
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
            endcase
        end
    end

endmodule
